// File: rtl/link_receiver.sv
// Receive side of the 16-bit K-char link: comma-based lock, out-of-band trigger recovery,
// and block framing into a first-word-fall-through FIFO with SOB/EOB/ERR flags.
module link_receiver #(
  parameter int DEPTH       = 64,
  parameter int LOCK_COMMAS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] rx_data,
  input  logic        rx_k,
  output logic        trig_out,
  output logic        sync,
  output logic [15:0] dout,
  output logic        dout_sob,
  output logic        dout_eob,
  output logic        dout_err,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [15:0] err_cnt,
  output logic [15:0] ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(LOCK_COMMAS + 1);

  typedef enum logic [1:0] {HUNT, SYNC, DROP} state_t;
  typedef enum logic [1:0] {C_COMMA, C_TRIG, C_DATA, C_BAD} cls_t;

  logic [15:0]   r_data;
  logic          r_k;
  cls_t          cls;
  state_t        state, state_next;
  logic [LW-1:0] comma_cnt, comma_next;
  logic          hold_valid, hold_v_next;
  logic          hold_sob, hold_sob_next;
  logic [15:0]   hold_data, hold_data_next;
  logic          sob_pend, sob_pend_next;
  logic          push, pop, err_inc, ovf_inc;
  logic [18:0]   push_entry;
  logic [18:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          room2, full;

  always_comb begin
    if (!r_k)                    cls = C_DATA;
    else if (r_data == 16'h00BC) cls = C_COMMA;
    else if (r_data == 16'h801C) cls = C_TRIG;
    else                         cls = C_BAD;
  end

  assign room2      = count <= CW'(DEPTH - 2);
  assign full       = count == CW'(DEPTH);
  assign dout_valid = count != '0;
  assign pop        = dout_valid && dout_ready;
  assign sync       = state == SYNC;
  assign {dout_err, dout_eob, dout_sob, dout} = dout_valid ? mem[rd_ptr] : '0;

  // The hold register delays each data word by one so its EOB flag is known when it is pushed.
  always_comb begin
    state_next     = state;
    comma_next     = comma_cnt;
    hold_v_next    = hold_valid;
    hold_sob_next  = hold_sob;
    hold_data_next = hold_data;
    sob_pend_next  = sob_pend;
    push           = 1'b0;
    push_entry     = '0;
    err_inc        = 1'b0;
    ovf_inc        = 1'b0;
    case (state)
      HUNT: begin
        hold_v_next = 1'b0;
        if (cls == C_COMMA) begin
          if (comma_cnt == LW'(LOCK_COMMAS - 1)) begin
            state_next    = SYNC;
            comma_next    = '0;
            sob_pend_next = 1'b1;
          end else begin
            comma_next = comma_cnt + 1'b1;
          end
        end else begin
          comma_next = '0;
        end
      end
      SYNC: begin
        case (cls)
          C_DATA: begin
            if (hold_valid && !room2) begin
              // Last free slot closes the block as truncated; the rest is dropped.
              push        = !full;
              push_entry  = {1'b1, 1'b1, hold_sob, hold_data};
              ovf_inc     = 1'b1;
              hold_v_next = 1'b0;
              state_next  = DROP;
            end else begin
              push           = hold_valid;
              push_entry     = {1'b0, 1'b0, hold_sob, hold_data};
              hold_v_next    = 1'b1;
              hold_data_next = r_data;
              hold_sob_next  = sob_pend;
              sob_pend_next  = 1'b0;
            end
          end
          C_COMMA: begin
            sob_pend_next = 1'b1;
            hold_v_next   = 1'b0;
            push          = hold_valid && !full;
            push_entry    = {1'b0, 1'b1, hold_sob, hold_data};
            ovf_inc       = hold_valid && full;
          end
          C_BAD: begin
            err_inc     = 1'b1;
            state_next  = HUNT;
            comma_next  = '0;
            hold_v_next = 1'b0;
            push        = hold_valid && !full;
            push_entry  = {1'b1, 1'b1, hold_sob, hold_data};
          end
          default: ;
        endcase
      end
      DROP: begin
        if (cls == C_COMMA) begin
          state_next    = SYNC;
          sob_pend_next = 1'b1;
        end else if (cls == C_BAD) begin
          err_inc    = 1'b1;
          state_next = HUNT;
          comma_next = '0;
        end
      end
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data     <= '0;
      r_k        <= 1'b0;
      state      <= HUNT;
      comma_cnt  <= '0;
      hold_valid <= 1'b0;
      hold_sob   <= 1'b0;
      hold_data  <= '0;
      sob_pend   <= 1'b0;
      trig_out   <= 1'b0;
      err_cnt    <= '0;
      ovf_cnt    <= '0;
    end else begin
      r_data     <= rx_data;
      r_k        <= rx_k;
      state      <= state_next;
      comma_cnt  <= comma_next;
      hold_valid <= hold_v_next;
      hold_sob   <= hold_sob_next;
      hold_data  <= hold_data_next;
      sob_pend   <= sob_pend_next;
      trig_out   <= (cls == C_TRIG) && (state != HUNT);
      if (err_inc && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
      if (ovf_inc && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

endmodule
